// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg
//   Shared types and constants for the boot-time instruction memory loader.
//   - loader_state_t : frame-parsing states
//   - BYTE_W         : width of one stream byte
//   - LEN_BYTES      : number of length bytes at the head of a frame
//   - CHK_BYTES      : number of checksum bytes at the tail of a frame
//   - LEN_W          : width of the frame word-count field
package imem_loader_pkg;

    localparam int BYTE_W    = 8;
    localparam int LEN_BYTES = 2;
    localparam int CHK_BYTES = 1;
    localparam int LEN_W     = LEN_BYTES * BYTE_W;

    typedef enum logic [2:0] {
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_CHK,
        ST_DONE,
        ST_ERR
    } loader_state_t;

    // States in which the loader consumes stream bytes.
    function automatic logic state_accepts(input loader_state_t s);
        return (s == ST_LEN_LO) || (s == ST_LEN_HI) || (s == ST_DATA) || (s == ST_CHK);
    endfunction

endpackage

// File: rtl/loader_word_assembler.sv
// loader_word_assembler
//   Collects stream bytes into DATA_W-bit words, little-endian (first byte
//   lands in the least significant lane).
//   Ports:
//     clk, rst     - clock, asynchronous active-high reset
//     clear        - discard any partially assembled word
//     byte_valid   - a byte is accepted this cycle
//     byte_data    - the accepted byte
//     word_valid   - this byte completes a word (combinational)
//     word_data    - the completed word, valid with word_valid
module loader_word_assembler
    import imem_loader_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              byte_valid,
    input  logic [BYTE_W-1:0] byte_data,
    output logic              word_valid,
    output logic [DATA_W-1:0] word_data
);

    localparam int BPW   = DATA_W / BYTE_W;
    localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;

    logic [CNT_W-1:0]  cnt_reg;
    logic [DATA_W-1:0] shift_reg;
    logic              last_byte;

    assign last_byte  = (cnt_reg == CNT_W'(BPW - 1));
    assign word_valid = byte_valid & last_byte;

    // Older bytes move down one lane; the newest byte enters the top lane,
    // so after BPW bytes the first one sits in bits [7:0].
    assign word_data = (shift_reg >> BYTE_W) | (DATA_W'(byte_data) << (DATA_W - BYTE_W));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg   <= '0;
            shift_reg <= '0;
        end else if (clear) begin
            cnt_reg   <= '0;
        end else if (byte_valid) begin
            shift_reg <= word_data;
            cnt_reg   <= last_byte ? '0 : cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// imem_loader
//   Boot loader in front of the CPU. Parses a framed byte stream
//   (LEN_LO, LEN_HI, N little-endian words, XOR checksum), writes the words
//   into instruction memory from address 0 and holds the CPU in reset until a
//   frame loads with a matching checksum.
//   Ports:
//     clk, rst           - clock, asynchronous active-high reset
//     in_valid/in_data   - byte stream; transfer when in_valid & in_ready
//     in_ready           - loader accepts bytes (LEN_LO..CHK, not in reset)
//     load_req           - restart pulse, honoured only in DONE/ERR
//     mem_we/addr/wdata  - registered instruction memory write port
//     cpu_rst            - CPU reset, released only in DONE
//     done, error        - frame accepted / frame rejected
//     words_loaded       - words written in the current frame
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_data,
    output logic              in_ready,
    input  logic              load_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    // A frame may fill memory exactly; one word more is rejected.
    localparam logic [31:0] CAPACITY = 32'd1 << ADDR_W;

    loader_state_t     state_reg, state_next;
    logic [BYTE_W-1:0] chk_reg, chk_next;
    logic [BYTE_W-1:0] len_lo_reg, len_lo_next;
    logic [ADDR_W:0]   len_reg, len_next;
    logic [ADDR_W:0]   words_reg, words_next, words_inc;
    logic              we_reg, we_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [DATA_W-1:0] wdata_reg, wdata_next;

    logic              accept;
    logic              asm_valid;
    logic              asm_clear;
    logic              word_valid;
    logic [DATA_W-1:0] word_data;
    logic [31:0]       len_in;

    assign in_ready  = state_accepts(state_reg) & ~rst;
    assign accept    = in_valid & in_ready;
    assign asm_valid = accept & (state_reg == ST_DATA);
    assign len_in    = {16'd0, in_data, len_lo_reg};
    assign words_inc = words_reg + 1'b1;

    loader_word_assembler #(.DATA_W(DATA_W)) u_asm (
        .clk        (clk),
        .rst        (rst),
        .clear      (asm_clear),
        .byte_valid (asm_valid),
        .byte_data  (in_data),
        .word_valid (word_valid),
        .word_data  (word_data)
    );

    always_comb begin
        state_next  = state_reg;
        chk_next    = chk_reg;
        len_lo_next = len_lo_reg;
        len_next    = len_reg;
        words_next  = words_reg;
        we_next     = 1'b0;
        addr_next   = addr_reg;
        wdata_next  = wdata_reg;
        asm_clear   = 1'b0;

        case (state_reg)
            ST_LEN_LO: begin
                if (accept) begin
                    chk_next    = in_data;
                    len_lo_next = in_data;
                    state_next  = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (accept) begin
                    chk_next = chk_reg ^ in_data;
                    len_next = len_in[ADDR_W:0];
                    if (len_in > CAPACITY) begin
                        state_next = ST_ERR;
                    end else if (len_in == 32'd0) begin
                        state_next = ST_CHK;
                    end else begin
                        state_next = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (accept) begin
                    chk_next = chk_reg ^ in_data;
                    if (word_valid) begin
                        we_next    = 1'b1;
                        addr_next  = words_reg[ADDR_W-1:0];
                        wdata_next = word_data;
                        words_next = words_inc;
                        if (words_inc == len_reg) begin
                            state_next = ST_CHK;
                        end
                    end
                end
            end
            ST_CHK: begin
                if (accept) begin
                    state_next = (in_data == chk_reg) ? ST_DONE : ST_ERR;
                end
            end
            ST_DONE, ST_ERR: begin
                if (load_req) begin
                    state_next  = ST_LEN_LO;
                    chk_next    = '0;
                    len_lo_next = '0;
                    len_next    = '0;
                    words_next  = '0;
                    asm_clear   = 1'b1;
                end
            end
            default: begin
                state_next = ST_LEN_LO;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= ST_LEN_LO;
            chk_reg    <= '0;
            len_lo_reg <= '0;
            len_reg    <= '0;
            words_reg  <= '0;
            we_reg     <= 1'b0;
            addr_reg   <= '0;
            wdata_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            chk_reg    <= chk_next;
            len_lo_reg <= len_lo_next;
            len_reg    <= len_next;
            words_reg  <= words_next;
            we_reg     <= we_next;
            addr_reg   <= addr_next;
            wdata_reg  <= wdata_next;
        end
    end

    assign mem_we       = we_reg;
    assign mem_addr     = addr_reg;
    assign mem_wdata    = wdata_reg;
    assign words_loaded = words_reg;
    assign done         = (state_reg == ST_DONE);
    assign error        = (state_reg == ST_ERR);
    assign cpu_rst      = (state_reg != ST_DONE);

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 8;
    localparam int CAP    = 1 << ADDR_W;

    typedef logic [7:0] byte_q_t[$];
    typedef struct {int addr; int data; int wl;} wr_t;
    typedef struct {bit ok; int wl;} cm_t;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              load_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              cpu_rst;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   words_loaded;

    wr_t wr_q[$];
    cm_t cm_q[$];
    int  checks = 0;
    int  errors = 0;
    bit  bp_en  = 0;

    imem_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .load_req     (load_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_rst      (cpu_rst),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: interpret a frame by the loader's rules and queue the
    // writes and the completion it must produce when the first 'limit' bytes
    // are offered. Returns the number of bytes the loader will accept.
    task automatic model(input byte_q_t frame, input int limit, output int nsend, output bit finishes);
        int  n;
        int  total;
        logic [7:0] x;
        n        = int'(frame[0]) | (int'(frame[1]) << 8);
        total    = frame.size();
        finishes = 1'b0;
        if (n > CAP) begin
            nsend = (limit < 2) ? limit : 2;
            if (nsend == 2) begin
                cm_q.push_back('{ok: 1'b0, wl: 0});
                finishes = 1'b1;
            end
        end else begin
            nsend = (limit < total) ? limit : total;
            for (int i = 0; i < n; i++) begin
                if (3 + 2 * i < nsend)
                    wr_q.push_back('{addr: i % CAP,
                                     data: int'(frame[2 + 2 * i]) | (int'(frame[3 + 2 * i]) << 8),
                                     wl: i + 1});
            end
            if (nsend == total) begin
                x = 8'h00;
                for (int i = 0; i < total - 1; i++) x = x ^ frame[i];
                cm_q.push_back('{ok: (x == frame[total - 1]), wl: n});
                finishes = 1'b1;
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int guard;
        guard = 0;
        @(negedge clk);
        if (bp_en) begin
            while ($urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                @(negedge clk);
            end
        end
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready) begin
            guard++;
            if (guard > 20) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: in_ready got 0 expected 1");
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        @(posedge clk);
    endtask

    task automatic send_frame(input byte_q_t frame, input int limit);
        int nsend;
        bit fin;
        model(frame, limit, nsend, fin);
        for (int i = 0; i < nsend; i++) send_byte(frame[i]);
        @(negedge clk);
        in_valid = 1'b0;
        if (fin) begin
            check("complete_latency", 32'(done | error), 1);
            check("ready_after_complete", 32'(in_ready), 0);
        end
    endtask

    task automatic gen_frame(input int n, input bit bad, output byte_q_t frame);
        logic [7:0] x;
        logic [7:0] b;
        frame = {};
        frame.push_back(8'(n));
        frame.push_back(8'(n >> 8));
        for (int i = 0; i < 2 * n; i++) begin
            b = 8'($urandom);
            frame.push_back(b);
        end
        x = 8'h00;
        foreach (frame[i]) x = x ^ frame[i];
        if (bad) x = x ^ 8'($urandom_range(1, 255));
        frame.push_back(x);
    endtask

    task automatic restart();
        @(negedge clk);
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        check("restart_cpu_rst", 32'(cpu_rst), 1);
        check("restart_done", 32'(done), 0);
        check("restart_error", 32'(error), 0);
        check("restart_words", 32'(words_loaded), 0);
        check("restart_ready", 32'(in_ready), 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_we"}, 32'(mem_we), 0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 0);
        check({tag, "_mem_wdata"}, 32'(mem_wdata), 0);
        check({tag, "_cpu_rst"}, 32'(cpu_rst), 1);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_error"}, 32'(error), 0);
        check({tag, "_words"}, 32'(words_loaded), 0);
        check({tag, "_in_ready"}, 32'(in_ready), 0);
    endtask

    // Monitor: compares every memory write and every completion against the
    // scoreboard queues filled by the stimulus side.
    initial begin
        wr_t e;
        cm_t c;
        bit  comp_prev;
        comp_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                comp_prev = 1'b0;
            end else begin
                if (mem_we) begin
                    if (wr_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write: got addr %0h data %0h expected none", mem_addr, mem_wdata);
                    end else begin
                        e = wr_q.pop_front();
                        check("write_addr", 32'(mem_addr), e.addr);
                        check("write_data", 32'(mem_wdata), e.data);
                        check("write_words", 32'(words_loaded), e.wl);
                    end
                end
                if ((done | error) && !comp_prev) begin
                    if (cm_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_completion: got done %0b error %0b expected none", done, error);
                    end else begin
                        c = cm_q.pop_front();
                        $display("completion: done=%0b error=%0b words=%0d", done, error, words_loaded);
                        check("comp_done", 32'(done), 32'(c.ok));
                        check("comp_error", 32'(error), 32'(!c.ok));
                        check("comp_cpu_rst", 32'(cpu_rst), 32'(!c.ok));
                        check("comp_words", 32'(words_loaded), c.wl);
                    end
                end
                comp_prev = done | error;
            end
        end
    end

    initial begin
        byte_q_t frame;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        load_req = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Reference frame from the datasheet example.
        frame = '{8'h02, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'h42};
        send_frame(frame, 1000);
        check("done_cpu_rst", 32'(cpu_rst), 0);
        // Bytes offered while DONE must be ignored (no write, state kept).
        in_valid = 1'b1;
        in_data  = 8'h5A;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        check("done_holds", 32'(done), 1);
        restart();

        frame = '{8'h02, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'h43};
        send_frame(frame, 1000);
        restart();

        frame = '{8'h00, 8'h00, 8'h00};
        send_frame(frame, 1000);
        restart();

        frame = '{8'h01, 8'h01};
        send_frame(frame, 1000);
        check("oversize_error", 32'(error), 1);
        restart();

        bp_en = 1'b1;
        gen_frame(CAP, 1'b0, frame);
        send_frame(frame, 100000);
        restart();

        for (int k = 0; k < 6; k++) begin
            gen_frame($urandom_range(1, 12), ($urandom_range(0, 2) == 0), frame);
            send_frame(frame, 100000);
            restart();
        end

        // Reset in the middle of DATA: two whole words and one stray byte.
        gen_frame(4, 1'b0, frame);
        send_frame(frame, 7);
        #2 rst = 1'b1;
        #1 check_reset_outputs("async_reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        gen_frame(5, 1'b0, frame);
        send_frame(frame, 100000);

        repeat (5) @(negedge clk);
        check("pending_writes", 32'(wr_q.size()), 0);
        check("pending_completions", 32'(cm_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader sitting directly upstream of `cpu`. Accepts a framed byte stream over a valid/ready interface, assembles little-endian instruction words, writes them into instruction memory from address 0, and verifies an XOR checksum. Holds the CPU in reset via `cpu_rst` until a frame loads cleanly, then releases it. Replaces the bench-driven `rst` release of the CPU.

## Interface
- `DATA_W`, 16, instruction word width; a multiple of 8, at least 8.
- `ADDR_W`, 8, instruction memory address width; capacity is 2^ADDR_W words.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  byte on `in_data` is valid.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  loader can accept a byte; transfer occurs when `in_valid & in_ready` at a rising edge.
- `load_req`  in  1  single-cycle pulse; restarts loading from DONE or ERR.
- `mem_we`  out  1  instruction memory write enable.
- `mem_addr`  out  ADDR_W  write address.
- `mem_wdata`  out  DATA_W  write data.
- `cpu_rst`  out  1  CPU reset, active-high.
- `done`  out  1  frame loaded and checksum matched.
- `error`  out  1  frame rejected.
- `words_loaded`  out  ADDR_W+1  words written in the current frame.

## Operation
- Frame layout: LEN_LO, LEN_HI (16-bit word count N), then N×(DATA_W/8) data bytes (each word little-endian), then one CHK byte.
- CHK must equal the XOR of every preceding frame byte, including both length bytes.
- States: LEN_LO, LEN_HI, DATA, CHK, DONE, ERR. Reset state is LEN_LO.
- LEN_LO → LEN_HI on accept.
- LEN_HI on accept:
  - If N > 2^ADDR_W → ERR. N = 2^ADDR_W is legal.
  - Else if N = 0 → CHK.
  - Else → DATA.
- DATA: byte counter and word counter.
  - When the last byte of a word is accepted, issue a write and increment `words_loaded`.
  - After word N is accepted → CHK.
- CHK on accept: match → DONE, mismatch → ERR.
- DONE/ERR:
  - `in_ready` = 0; incoming bytes are ignored.
  - `load_req` → LEN_LO. This clears the checksum, counters, `done`, `error` and `words_loaded`, and asserts `cpu_rst`.
- `load_req` is ignored in LEN_LO, LEN_HI, DATA and CHK.
- `in_ready` = 1 in LEN_LO, LEN_HI, DATA and CHK while `rst` is low; it is 0 while `rst` is high.
- `cpu_rst` = 1 in every state except DONE.
- `mem_addr` = the index of the word being written, starting at 0. When N = 2^ADDR_W, the address wraps naturally and no extra write occurs.
- Reset mid-frame: all state is discarded and the next byte is treated as LEN_LO. Partial memory contents are left as-is.

## Timing
- Reset values: `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0, `cpu_rst` = 1, `done` = 0, `error` = 0, `words_loaded` = 0.
- Write latency: `mem_we`, `mem_addr` and `mem_wdata` are registered. `mem_we` is high for exactly one cycle, the cycle after the final byte of a word is accepted.
- `words_loaded` updates in the same cycle that `mem_we` is high.
- Completion: on the cycle after CHK is accepted, exactly one of these occurs:
  - `done` = 1 and `cpu_rst` = 0;
  - `error` = 1 and `cpu_rst` = 1.
- Oversize length: `error` rises on the cycle after LEN_HI is accepted.
- After `load_req`, the loader is in LEN_LO on the next cycle, with `cpu_rst` = 1, `done` = 0 and `error` = 0.
- Throughput: one byte per cycle. `in_ready` never depends on `in_valid`.
- `in_valid` low stalls the frame indefinitely; there is no timeout.

## Structure
- Package `imem_loader_pkg`: state enum `loader_state_t`, `BYTE_W` = 8, and frame-position constants.
- Sub-module `loader_word_assembler`: shifts accepted bytes into a DATA_W register, little-endian. It emits `word_valid` when the last byte lands and clears its byte count on `clear`.
- Top level holds the FSM, checksum register, address/word counters and memory-write registers.
- `tb_cpu` instantiates `imem_loader` in front of `cpu` and drives `cpu`'s reset from `cpu_rst`.

## Test plan
- Normal load (DATA_W=16): bytes 02 00 34 12 CD AB 42 →
  - writes (addr 0, 0x1234) and (addr 1, 0xABCD);
  - `done` = 1, `cpu_rst` = 0, `words_loaded` = 2.
- Bad checksum: the same frame with CHK = 43 → two writes occur, then `error` = 1 and `cpu_rst` stays 1.
- Zero length: 00 00 00 → no writes; `done` = 1, `words_loaded` = 0.
- Bounds (ADDR_W=8):
  - LEN = 0x0101 → `error` the cycle after LEN_HI; `in_ready` = 0 afterwards.
  - LEN = 0x0100 → 256 writes, addresses 0..255; `words_loaded` = 256.
- Backpressure and restart:
  - `in_valid` toggled randomly during a normal load → identical writes.
  - `load_req` pulse after DONE, then a second frame → `cpu_rst` reasserts, the new data loads and `done` is set again.
- Async reset asserted mid-DATA → outputs return to reset values immediately; a following full frame loads correctly.
